// File: rtl/ofmap_write_arbiter.sv
// ---------------------------------------------------------------------------
// ofmap_write_arbiter
//
// Purpose:
//   Several output routers each hold a burst of output-feature-map results.
//   They all share one scratchpad (SPAD) write port. This block drains them
//   one at a time in round-robin order. Each word is written to consecutive
//   SPAD addresses starting from a base address that is captured at pass start.
//   Once every router has been served once, the block pulses o_done.
//
// Ports:
//   i_clk, i_nrst      clock, asynchronous active-low reset
//   i_start            single-cycle pulse that begins a pass (only honoured in IDLE)
//   i_base_addr        first SPAD address of the pass, captured with i_start
//   i_req              per-router "results ready" request
//   o_router_en        one-hot (or zero) enable to the currently granted router
//   i_router_data      per-router data word, element r belongs to router r
//   i_router_valid     per-router word valid
//   i_router_done      per-router end-of-burst pulse
//   o_spad_we/addr/data registered SPAD write port; addr/data hold when we=0
//   o_busy             high from the accepted start until the o_done cycle
//   o_done             single-cycle end-of-pass pulse
//   o_overflow         sticky flag: a router sent more than BURST_LEN words
// ---------------------------------------------------------------------------
module ofmap_write_arbiter #(
  parameter int ROW_COUNT       = 4,
  parameter int SPAD_ADDR_WIDTH = 8,
  parameter int SPAD_DATA_WIDTH = 16,
  parameter int BURST_LEN       = 2
) (
  input  logic                                          i_clk,
  input  logic                                          i_nrst,
  input  logic                                          i_start,
  input  logic [SPAD_ADDR_WIDTH-1:0]                    i_base_addr,
  input  logic [ROW_COUNT-1:0]                          i_req,
  output logic [ROW_COUNT-1:0]                          o_router_en,
  input  logic [ROW_COUNT-1:0][SPAD_DATA_WIDTH-1:0]     i_router_data,
  input  logic [ROW_COUNT-1:0]                          i_router_valid,
  input  logic [ROW_COUNT-1:0]                          i_router_done,
  output logic                                          o_spad_we,
  output logic [SPAD_ADDR_WIDTH-1:0]                    o_spad_addr,
  output logic [SPAD_DATA_WIDTH-1:0]                    o_spad_data,
  output logic                                          o_busy,
  output logic                                          o_done,
  output logic                                          o_overflow
);

  localparam int IDX_W  = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(ROW_COUNT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARB    = 2'd1;
  localparam logic [1:0] ST_GRANT  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [1:0]                 state;
  logic [ROW_COUNT-1:0]       served;
  logic [IDX_W-1:0]           rr_ptr;
  logic [IDX_W-1:0]           grant_idx;
  logic [SPAD_ADDR_WIDTH-1:0] addr_ptr;
  logic [BEAT_W-1:0]          beat_cnt;

  logic [ROW_COUNT-1:0]       eligible;
  logic                       all_served;
  logic                       grant_found;
  logic [IDX_W-1:0]           grant_next;
  logic [IDX_W-1:0]           cand;
  logic                       g_valid;
  logic                       g_done;
  logic [SPAD_DATA_WIDTH-1:0] g_data;

  assign eligible   = i_req & ~served;
  assign all_served = &served;

  // Only the granted router's handshake is ever looked at, so traffic from
  // other routers is ignored without any extra masking.
  assign g_valid = i_router_valid[grant_idx];
  assign g_done  = i_router_done[grant_idx];
  assign g_data  = i_router_data[grant_idx];

  // Round-robin pick: first eligible router at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_next  = '0;
    cand        = '0;
    for (int i = 0; i < ROW_COUNT; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % ROW_COUNT);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_next  = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= ST_IDLE;
      served      <= '0;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      addr_ptr    <= '0;
      beat_cnt    <= '0;
      o_router_en <= '0;
      o_spad_we   <= 1'b0;
      o_spad_addr <= '0;
      o_spad_data <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_spad_we <= 1'b0;
      o_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            addr_ptr   <= i_base_addr;
            served     <= '0;
            rr_ptr     <= '0;
            o_overflow <= 1'b0;
            o_busy     <= 1'b1;
            state      <= ST_ARB;
          end
        end
        ST_ARB: begin
          // o_done is registered, so it is raised on entry to FINISH and is
          // therefore high exactly while the FSM sits in FINISH.
          if (all_served) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_FINISH;
          end else if (grant_found) begin
            grant_idx   <= grant_next;
            o_router_en <= ROW_COUNT'(1) << grant_next;
            beat_cnt    <= '0;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Valid and done are handled independently so a final word that
          // arrives together with done is still written.
          if (g_valid) begin
            if (beat_cnt < BEAT_MAX) begin
              o_spad_we   <= 1'b1;
              o_spad_addr <= addr_ptr;
              o_spad_data <= g_data;
              addr_ptr    <= addr_ptr + SPAD_ADDR_WIDTH'(1);
              beat_cnt    <= beat_cnt + BEAT_W'(1);
            end else begin
              o_overflow <= 1'b1;
            end
          end
          if (g_done) begin
            served[grant_idx] <= 1'b1;
            rr_ptr            <= (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
            o_router_en       <= '0;
            state             <= ST_ARB;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ofmap_write_arbiter
//
// Purpose:
//   Self-checking bench for ofmap_write_arbiter. Router behaviour is played by
//   the bench: whichever router is enabled sends its planned words and then
//   ends its burst. The expected SPAD write stream is built from the pass plan
//   by walking routers in service order. Each router contributes up to
//   BURST_LEN words at consecutive base-relative addresses, and any extra
//   words mark an overflow.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_ofmap_write_arbiter;

  localparam int ROWS = 4;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int BL   = 2;

  logic                     clk = 1'b0;
  logic                     nrst = 1'b0;
  logic                     start = 1'b0;
  logic [AW-1:0]            base_addr = '0;
  logic [ROWS-1:0]          req = '0;
  logic [ROWS-1:0]          router_en;
  logic [ROWS-1:0][DW-1:0]  router_data = '0;
  logic [ROWS-1:0]          router_valid = '0;
  logic [ROWS-1:0]          router_done = '0;
  logic                     spad_we;
  logic [AW-1:0]            spad_addr;
  logic [DW-1:0]            spad_data;
  logic                     busy;
  logic                     pass_done;
  logic                     overflow;

  int checks = 0;
  int errors = 0;

  // Plan for the routers in the current pass.
  int          plan_beats [ROWS];
  bit          plan_merge [ROWS];
  logic [DW-1:0] plan_data [ROWS][4];
  bit          intrude_en = 1'b0;

  logic [AW-1:0] got_addr [$];
  logic [DW-1:0] got_data [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  int            order_q  [$];
  int            exp_order [$];
  int            done_count = 0;

  ofmap_write_arbiter #(
    .ROW_COUNT(ROWS), .SPAD_ADDR_WIDTH(AW), .SPAD_DATA_WIDTH(DW), .BURST_LEN(BL)
  ) dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_base_addr(base_addr),
    .i_req(req), .o_router_en(router_en), .i_router_data(router_data),
    .i_router_valid(router_valid), .i_router_done(router_done),
    .o_spad_we(spad_we), .o_spad_addr(spad_addr), .o_spad_data(spad_data),
    .o_busy(busy), .o_done(pass_done), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  // Capture every SPAD write and every end-of-pass pulse.
  always @(negedge clk) begin
    if (spad_we === 1'b1) begin
      got_addr.push_back(spad_addr);
      got_data.push_back(spad_data);
    end
    if (pass_done === 1'b1) done_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_plan_uniform(input int beats);
    for (int r = 0; r < ROWS; r++) begin
      plan_beats[r] = beats;
      plan_merge[r] = 1'b0;
      for (int b = 0; b < 4; b++) plan_data[r][b] = DW'(16'h1000 + r * 16'h100 + b);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_busy: busy=%b required 1", busy);
    end
  endtask

  // Act as the routers: for each grant, send the planned words, then end the burst.
  task automatic respond_grants(input int ngrants);
    for (int k = 0; k < ngrants; k++) begin
      int r;
      int w;
      int o;
      r = 0;
      w = 0;
      while (router_en == '0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (!$onehot(router_en)) begin
        errors++;
        $display("[TB] FAIL grant_wait: router_en=%b required one-hot", router_en);
        return;
      end
      for (int i = 0; i < ROWS; i++) if (router_en[i]) r = i;
      order_q.push_back(r);
      o = (r + 1) % ROWS;
      for (int b = 0; b < plan_beats[r]; b++) begin
        router_valid[r] = 1'b1;
        router_data[r]  = plan_data[r][b];
        router_done[r]  = plan_merge[r] && (b == plan_beats[r] - 1);
        if (intrude_en && k == 0) begin
          router_valid[o] = 1'b1;
          router_done[o]  = 1'b1;
          router_data[o]  = 16'hDEAD;
        end
        @(negedge clk);
        router_valid = '0;
        router_done  = '0;
      end
      if (!(plan_merge[r] && plan_beats[r] > 0)) begin
        router_done[r] = 1'b1;
        if (intrude_en && k == 0) begin
          router_valid[o] = 1'b1;
          router_done[o]  = 1'b1;
          router_data[o]  = 16'hDEAD;
        end
        @(negedge clk);
        router_valid = '0;
        router_done  = '0;
      end
      checks++;
      if (router_en[r] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL en_release: router_en=%b required bit %0d low", router_en, r);
      end
    end
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    while (pass_done !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (pass_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done_timeout: o_done=%b required 1", name, pass_done);
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s busy_at_done: busy=%b required 0", name, busy);
      end
      @(negedge clk);
      checks++;
      if (pass_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s done_width: o_done=%b required 0", name, pass_done);
      end
    end
  endtask

  // Modes: 0 plain, 1 intruding non-granted router, 2 second start while busy,
  // 3 late-arriving requests (r2 first, then r0, then the rest).
  task automatic run_pass(input logic [AW-1:0] base, input int mode, input string name);
    int d0;
    bit exp_ovf;
    logic [AW-1:0] a;
    int n;
    exp_order.delete(); exp_addr.delete(); exp_data.delete();
    got_addr.delete(); got_data.delete(); order_q.delete();
    if (mode == 3) exp_order = '{2, 0, 1, 3};
    else for (int r = 0; r < ROWS; r++) exp_order.push_back(r);
    exp_ovf = 1'b0;
    a = base;
    foreach (exp_order[k]) begin
      for (int b = 0; b < plan_beats[exp_order[k]]; b++) begin
        if (b < BL) begin
          exp_addr.push_back(a);
          exp_data.push_back(plan_data[exp_order[k]][b]);
          a = a + 1'b1;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    d0 = done_count;
    intrude_en = (mode == 1);
    if (mode == 1) begin
      router_valid[3] = 1'b1;
      router_done[3]  = 1'b1;
      router_data[3]  = 16'hDEAD;
      @(negedge clk);
      router_valid = '0;
      router_done  = '0;
    end
    req = (mode == 3) ? 4'b0100 : 4'b1111;
    pulse_start(base);
    fork
      respond_grants(ROWS);
      begin
        if (mode == 2) begin
          repeat (3) @(negedge clk);
          start = 1'b1;
          base_addr = ~base;
          @(negedge clk);
          start = 1'b0;
        end else if (mode == 3) begin
          repeat (4) @(negedge clk);
          req = 4'b0101;
          repeat (20) @(negedge clk);
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s busy_partial: busy=%b required 1", name, busy);
          end
          checks++;
          if (done_count != d0) begin
            errors++;
            $display("[TB] FAIL %s early_done: pulses=%0d required 0", name, done_count - d0);
          end
          req = 4'b1111;
        end
      end
    join
    wait_done(name);
    repeat (2) @(negedge clk);
    checks++;
    if (order_q.size() != exp_order.size()) begin
      errors++;
      $display("[TB] FAIL %s grant_count: got %0d required %0d", name, order_q.size(), exp_order.size());
    end else begin
      foreach (exp_order[k]) begin
        checks++;
        if (order_q[k] != exp_order[k]) begin
          errors++;
          $display("[TB] FAIL %s grant_order[%0d]: got r%0d required r%0d", name, k, order_q[k], exp_order[k]);
        end
      end
    end
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL %s write_count: got %0d required %0d", name, got_addr.size(), exp_addr.size());
    end
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("[TB] FAIL %s write[%0d]: got %h@%h required %h@%h", name, i,
                 got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("[TB] FAIL %s overflow: got %b required %b", name, overflow, exp_ovf);
    end
    checks++;
    if (done_count - d0 != 1) begin
      errors++;
      $display("[TB] FAIL %s done_pulses: got %0d required 1", name, done_count - d0);
    end
    intrude_en = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    start = 1'b1;
    req = '1;
    router_valid = '1;
    router_done = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (router_en !== '0 || spad_we !== 1'b0 || busy !== 1'b0 || pass_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: en=%b we=%b busy=%b done=%b required all 0",
               router_en, spad_we, busy, pass_done);
    end
    checks++;
    if (spad_addr !== '0 || spad_data !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: addr=%h data=%h ovf=%b required all 0", spad_addr, spad_data, overflow);
    end
    start = 1'b0;
    req = '0;
    router_valid = '0;
    router_done = '0;
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || router_en !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy=%b en=%b required 0", busy, router_en);
    end
  endtask

  task automatic test_basic_pass();
    set_plan_uniform(2);
    run_pass(8'h10, 0, "basic");
  endtask

  task automatic test_addr_wrap();
    set_plan_uniform(0);
    plan_beats[0] = 2;
    plan_beats[1] = 2;
    plan_merge[1] = 1'b1;
    run_pass(8'hFE, 0, "wrap");
  endtask

  task automatic test_overflow_sticky();
    set_plan_uniform(2);
    plan_beats[0] = 3;
    run_pass(8'h30, 0, "overflow");
    repeat (5) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: got %b required 1", overflow);
    end
    set_plan_uniform(2);
    run_pass(8'h20, 2, "double_start");
  endtask

  task automatic test_nongranted_ignored();
    set_plan_uniform(2);
    run_pass(8'h50, 1, "intruder");
  endtask

  task automatic test_random_passes();
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        plan_beats[r] = $urandom_range(0, 3);
        plan_merge[r] = 1'($urandom_range(0, 1));
        for (int b = 0; b < 4; b++) plan_data[r][b] = DW'($urandom_range(0, 16'h7FFF));
      end
      run_pass(AW'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_late_request();
    set_plan_uniform(2);
    run_pass(8'h00, 3, "late_req");
  endtask

  task automatic test_reset_midpass();
    int w;
    set_plan_uniform(2);
    got_addr.delete();
    got_data.delete();
    order_q.delete();
    req = '1;
    pulse_start(8'h40);
    respond_grants(1);
    w = 0;
    while (router_en == '0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (router_en !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL midrst_grant: en=%b required 0010", router_en);
    end
    router_valid[1] = 1'b1;
    router_data[1] = 16'h0A11;
    @(negedge clk);
    router_data[1] = 16'h0B22;
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (router_en !== '0 || spad_we !== 1'b0 || spad_addr !== '0 || spad_data !== '0 ||
        busy !== 1'b0 || pass_done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: en=%b we=%b addr=%h data=%h busy=%b ovf=%b required all 0",
               router_en, spad_we, spad_addr, spad_data, busy, overflow);
    end
    router_valid = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      router_valid = ROWS'($urandom_range(0, 15));
      router_done  = ROWS'($urandom_range(0, 15));
      @(negedge clk);
    end
    router_valid = '0;
    router_done = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || router_en !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_idle: busy=%b en=%b required 0", busy, router_en);
    end
    checks++;
    if (got_addr.size() != 3) begin
      errors++;
      $display("[TB] FAIL midrst_writes: got %0d writes required 3", got_addr.size());
    end else begin
      checks++;
      if (got_addr[2] !== 8'h42 || got_data[2] !== 16'h0A11) begin
        errors++;
        $display("[TB] FAIL midrst_last_write: got %h@%h required 0a11@42", got_data[2], got_addr[2]);
      end
    end
  endtask

  initial begin
    $display("[TB] starting ofmap_write_arbiter bench");
    test_reset();
    test_basic_pass();
    test_addr_wrap();
    test_overflow_sticky();
    test_nongranted_ignored();
    test_random_passes();
    test_reset_midpass();
    test_late_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
